flood_fill_engine: RTL and testbench

- Executes one Flood-It move on the board memory.
- On a colour-select pulse from the selector, it repaints the flooded region anchored at cell (0,0) to the chosen colour.
- It then grows the region over same-coloured orthogonal neighbours until stable, updates the try count and reports a win.
- Sits between the selector (upstream: colour pulse, size, init) and the board RAM that the VGA display reads (downstream).

---
 rtl/flood_fill_engine.sv | 186 ++++++++++++++++++
 tb/tb_flood_fill_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_fill_engine.sv
`default_nettype none
//============================================================================
// Module   : flood_fill_engine
// Purpose  : Executes one Flood-It move: repaints the region anchored at
//            (0,0), then grows it over same-coloured neighbours until stable.
// Revision : 1.0 - initial release
//============================================================================
module flood_fill_engine #(
    parameter int MAX_SIZE = 26,
    parameter int ADDR_W   = 10
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              INIT,
    input  logic [4:0]        SIZE,
    input  logic              COLOR_SEL_SIG,
    input  logic [2:0]        COLOR_SELECTED,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [2:0]        RD_DATA,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [2:0]        WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              WON,
    output logic [7:0]        TRIES
);

    localparam int                c_cells      = MAX_SIZE * MAX_SIZE;
    localparam logic [ADDR_W-1:0] c_row_stride = ADDR_W'(MAX_SIZE);
    localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_RD   = 3'd1,
        S_INIT_WAIT = 3'd2,
        S_PAINT     = 3'd3,
        S_EXP_ADDR  = 3'd4,
        S_EXP_EVAL  = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cells-1:0]  r_owned;
    logic [2:0]          r_cur_color;
    logic [ADDR_W-1:0]   r_owned_cnt;
    logic                r_changed;
    logic                r_inited;
    logic                r_won;
    logic [4:0]          r_size;
    logic [4:0]          r_row;
    logic [4:0]          r_col;
    logic [7:0]          r_tries;

    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_area;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_last_cell;
    logic [4:0]          w_col_next;
    logic [4:0]          w_row_next;
    logic                w_nb_owned;
    logic                w_grow;
    logic                w_accept;
    logic                w_pass_changed;

    assign w_addr      = ADDR_W'(r_row) * c_row_stride + ADDR_W'(r_col);
    assign w_area      = ADDR_W'(r_size) * ADDR_W'(r_size);
    assign w_last_col  = (r_col == r_size - 5'd1);
    assign w_last_row  = (r_row == r_size - 5'd1);
    assign w_last_cell = w_last_col && w_last_row;
    assign w_col_next  = w_last_col ? 5'd0 : r_col + 5'd1;
    assign w_row_next  = w_last_col ? (w_last_row ? 5'd0 : r_row + 5'd1) : r_row;

    // Only in-range neighbours count; the guards keep edge cells from
    // peeking at the wrapped row/column of the fixed-stride bitmap.
    assign w_nb_owned = ((r_row != 5'd0) && r_owned[w_addr - c_row_stride]) ||
                        (!w_last_row     && r_owned[w_addr + c_row_stride]) ||
                        ((r_col != 5'd0) && r_owned[w_addr - c_one])        ||
                        (!w_last_col     && r_owned[w_addr + c_one]);

    assign w_grow = (r_state == S_EXP_EVAL) && !r_owned[w_addr] &&
                    (RD_DATA == r_cur_color) && w_nb_owned;
    assign w_pass_changed = r_changed || w_grow;

    assign w_accept = (r_state == S_IDLE) && COLOR_SEL_SIG && r_inited &&
                      !r_won && (COLOR_SELECTED != r_cur_color);

    assign RD_ADDR = w_addr;
    assign WR_ADDR = w_addr;
    assign WR_DATA = r_cur_color;
    assign WON     = r_won;
    assign TRIES   = r_tries;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = (r_state != S_IDLE) && (r_state != S_FINISH);
        DONE         = (r_state == S_FINISH);
        WR_EN        = (r_state == S_PAINT) && r_owned[w_addr];
        if (INIT) begin
            w_state_next = S_INIT_RD;
        end else begin
            case (r_state)
                S_IDLE:      if (w_accept) w_state_next = S_PAINT;
                S_INIT_RD:   w_state_next = S_INIT_WAIT;
                S_INIT_WAIT: w_state_next = S_EXP_ADDR;
                S_PAINT:     if (w_last_cell) w_state_next = S_EXP_ADDR;
                S_EXP_ADDR:  w_state_next = S_EXP_EVAL;
                S_EXP_EVAL: begin
                    if (w_last_cell && !w_pass_changed) w_state_next = S_FINISH;
                    else                                w_state_next = S_EXP_ADDR;
                end
                S_FINISH:    w_state_next = S_IDLE;
                default:     w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_owned     <= '0;
            r_cur_color <= 3'd0;
            r_owned_cnt <= '0;
            r_changed   <= 1'b0;
            r_inited    <= 1'b0;
            r_won       <= 1'b0;
            r_size      <= 5'd0;
            r_row       <= 5'd0;
            r_col       <= 5'd0;
            r_tries     <= 8'd0;
        end else if (INIT) begin
            // INIT pre-empts everything, including a move already in flight.
            r_row  <= 5'd0;
            r_col  <= 5'd0;
            r_size <= SIZE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cur_color <= COLOR_SELECTED;
                        if (r_tries != 8'hFF) r_tries <= r_tries + 8'd1;
                    end
                end
                S_INIT_RD: begin
                    r_owned     <= '0;
                    r_owned[0]  <= 1'b1;
                    r_owned_cnt <= c_one;
                    r_tries     <= 8'd0;
                    r_won       <= 1'b0;
                    r_inited    <= 1'b1;
                end
                S_INIT_WAIT: r_cur_color <= RD_DATA;
                S_PAINT: begin
                    r_row <= w_row_next;
                    r_col <= w_col_next;
                end
                S_EXP_ADDR: begin
                    if (r_row == 5'd0 && r_col == 5'd0) r_changed <= 1'b0;
                end
                S_EXP_EVAL: begin
                    if (w_grow) begin
                        r_owned[w_addr] <= 1'b1;
                        r_owned_cnt     <= r_owned_cnt + c_one;
                        r_changed       <= 1'b1;
                    end
                    // A quiet final pass means the count is settled.
                    if (w_last_cell && !w_pass_changed) r_won <= (r_owned_cnt == w_area);
                    r_row <= w_row_next;
                    r_col <= w_col_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flood_fill_engine.sv
`default_nettype none
//============================================================================
// Module   : tb_flood_fill_engine
// Purpose  : Directed self-checking bench for flood_fill_engine with a
//            one-cycle-latency board RAM model.
// Revision : 1.0 - initial release
//============================================================================
module tb_flood_fill_engine;

    logic       CLOCK;
    logic       RESET;
    logic       INIT;
    logic [4:0] SIZE;
    logic       COLOR_SEL_SIG;
    logic [2:0] COLOR_SELECTED;
    logic [9:0] RD_ADDR;
    logic [2:0] RD_DATA;
    logic       WR_EN;
    logic [9:0] WR_ADDR;
    logic [2:0] WR_DATA;
    logic       BUSY;
    logic       DONE;
    logic       WON;
    logic [7:0] TRIES;

    logic [2:0] mem [0:1023];
    logic       ld_en;
    logic       ld_clr;
    logic [9:0] ld_addr;
    logic [2:0] ld_data;
    int         wr_cnt = 0;
    logic [9:0] last_wr_addr;
    logic [2:0] last_wr_data;

    int errors = 0;
    int checks = 0;

    flood_fill_engine #(.MAX_SIZE(26), .ADDR_W(10)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .INIT(INIT), .SIZE(SIZE),
        .COLOR_SEL_SIG(COLOR_SEL_SIG), .COLOR_SELECTED(COLOR_SELECTED),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE),
        .WON(WON), .TRIES(TRIES)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) begin
        RD_DATA <= mem[RD_ADDR];
        if (ld_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 3'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (WR_EN === 1'b1) begin
            mem[WR_ADDR] <= WR_DATA;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= WR_ADDR;
            last_wr_data <= WR_DATA;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [2:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Pulse INIT or a colour select, optionally inject a second pulse at
    // cycle mid_k, and wait (bounded) for DONE; returns to IDLE afterwards.
    task automatic op(input bit is_init, input logic [4:0] s, input logic [2:0] c,
                      input int mid_k, input bit mid_init, input logic [2:0] mid_c,
                      output int n, output int busy_n, output logic got_done);
        if (is_init) begin
            INIT = 1'b1;
            SIZE = s;
        end else begin
            COLOR_SEL_SIG  = 1'b1;
            COLOR_SELECTED = c;
        end
        tick();
        INIT          = 1'b0;
        COLOR_SEL_SIG = 1'b0;
        n      = 1;
        busy_n = (BUSY === 1'b1) ? 1 : 0;
        while (DONE !== 1'b1 && n < 400) begin
            if (n == mid_k) begin
                if (mid_init) INIT = 1'b1;
                else begin
                    COLOR_SEL_SIG  = 1'b1;
                    COLOR_SELECTED = mid_c;
                end
            end
            tick();
            INIT          = 1'b0;
            COLOR_SEL_SIG = 1'b0;
            n++;
            if (BUSY === 1'b1) busy_n++;
        end
        got_done = DONE;
        tick();
    endtask

    task automatic reject(input string tag, input logic [2:0] c, input logic [7:0] exp_tries);
        COLOR_SEL_SIG  = 1'b1;
        COLOR_SELECTED = c;
        tick();
        COLOR_SEL_SIG  = 1'b0;
        check({tag, "_busy"}, BUSY, 0);
        tick();
        check({tag, "_done"}, DONE, 0);
        check({tag, "_tries"}, TRIES, exp_tries);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_won"}, WON, 0);
        check({tag, "_tries"}, TRIES, 0);
        check({tag, "_wr_en"}, WR_EN, 0);
        check({tag, "_rd_addr"}, RD_ADDR, 0);
        check({tag, "_wr_addr"}, WR_ADDR, 0);
        check({tag, "_wr_data"}, WR_DATA, 0);
    endtask

    initial begin
        int   n;
        int   b;
        int   w0;
        int   total;
        logic d;

        RESET = 1'b1; INIT = 1'b0; SIZE = 5'd0; COLOR_SEL_SIG = 1'b0;
        COLOR_SELECTED = 3'd0; ld_en = 1'b0; ld_clr = 1'b1; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        ld_clr = 1'b0;
        RESET  = 1'b0;
        check_idle_outputs("reset");
        reject("sel_before_init", 3'd1, 8'd0);

        // SIZE=2 board {0,1 / 1,1}
        load(10'd0, 3'd0); load(10'd1, 3'd1); load(10'd26, 3'd1); load(10'd27, 3'd1);
        w0 = wr_cnt;
        op(1'b1, 5'd2, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("init2_done", d, 1);
        check("init2_cycles", n, 11);
        check("init2_busy", b, 10);
        check("init2_won", WON, 0);
        check("init2_tries", TRIES, 0);
        check("init2_writes", wr_cnt - w0, 0);
        reject("same_color", 3'd0, 8'd0);

        w0 = wr_cnt;
        op(1'b0, 5'd0, 3'd1, -1, 1'b0, 3'd0, n, b, d);
        check("move1_done", d, 1);
        check("move1_cycles", n, 21);
        check("move1_busy", b, 20);
        check("move1_writes", wr_cnt - w0, 1);
        check("move1_wr_addr", last_wr_addr, 0);
        check("move1_wr_data", last_wr_data, 1);
        check("move1_won", WON, 1);
        check("move1_tries", TRIES, 1);
        reject("after_win", 3'd2, 8'd1);

        // SIZE=3 snake {0,1,1 / 2,2,1 / 1,1,1}
        load(10'd0, 3'd0);  load(10'd1, 3'd1);  load(10'd2, 3'd1);
        load(10'd26, 3'd2); load(10'd27, 3'd2); load(10'd28, 3'd1);
        load(10'd52, 3'd1); load(10'd53, 3'd1); load(10'd54, 3'd1);
        op(1'b1, 5'd3, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("snake_init_cycles", n, 21);
        check("snake_init_won", WON, 0);
        w0 = wr_cnt;
        op(1'b0, 5'd0, 3'd1, -1, 1'b0, 3'd0, n, b, d);
        check("snake_m1_cycles", n, 82);
        check("snake_m1_busy", b, 81);
        check("snake_m1_writes", wr_cnt - w0, 1);
        check("snake_m1_won", WON, 0);
        check("snake_m1_tries", TRIES, 1);
        check("snake_ram_1_0", mem[26], 2);
        check("snake_ram_1_1", mem[27], 2);
        w0 = wr_cnt;
        op(1'b0, 5'd0, 3'd2, -1, 1'b0, 3'd0, n, b, d);
        check("snake_m2_cycles", n, 46);
        check("snake_m2_writes", wr_cnt - w0, 7);
        check("snake_m2_won", WON, 1);
        check("snake_m2_tries", TRIES, 2);
        check("snake_ram_2_2", mem[54], 2);

        // SIZE=2 board {0,1 / 2,3}: select ignored while busy
        load(10'd0, 3'd0); load(10'd1, 3'd1); load(10'd26, 3'd2); load(10'd27, 3'd3);
        op(1'b1, 5'd2, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("b4_init_cycles", n, 11);
        reject("b4_same_color", 3'd0, 8'd0);
        op(1'b0, 5'd0, 3'd3, 3, 1'b0, 3'd1, n, b, d);
        check("busy_sel_cycles", n, 13);
        check("busy_sel_busy", b, 12);
        check("busy_sel_tries", TRIES, 1);

        // Reset in the middle of PAINT
        op(1'b1, 5'd2, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("b5_init_cycles", n, 11);
        COLOR_SEL_SIG  = 1'b1;
        COLOR_SELECTED = 3'd1;
        tick();
        COLOR_SEL_SIG  = 1'b0;
        check("paint_wr_en", WR_EN, 1);
        check("paint_wr_data", WR_DATA, 1);
        check("paint_tries", TRIES, 1);
        tick();
        check("paint_wr_addr", WR_ADDR, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_idle_outputs("mid_reset");
        reject("sel_after_reset", 3'd2, 8'd0);

        // INIT during an expansion pass; board is now {1,1 / 2,3}
        op(1'b1, 5'd2, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("b6_init_cycles", n, 19);
        check("b6_init_won", WON, 0);
        op(1'b0, 5'd0, 3'd2, 6, 1'b1, 3'd0, n, b, d);
        check("abort_done", d, 1);
        check("abort_cycles", n, 25);
        check("abort_busy", b, 24);
        check("abort_tries", TRIES, 0);
        check("abort_won", WON, 0);

        // TRIES saturation: owned cell alternates 4/5, neighbours never match
        load(10'd0, 3'd5); load(10'd1, 3'd7); load(10'd26, 3'd7); load(10'd27, 3'd6);
        op(1'b1, 5'd2, 3'd0, -1, 1'b0, 3'd0, n, b, d);
        check("sat_init_cycles", n, 11);
        total = 0;
        for (int i = 0; i < 260; i++) begin
            op(1'b0, 5'd0, (i % 2 == 0) ? 3'd4 : 3'd5, -1, 1'b0, 3'd0, n, b, d);
            total += n;
            if (i == 254) check("sat_tries_255", TRIES, 255);
        end
        check("sat_total_cycles", total, 260 * 13);
        check("sat_tries_final", TRIES, 255);
        check("sat_won", WON, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
